// File: rtl/commit_unit_if.sv
// commit_unit_if: active-list head, store-queue head, D-cache write port and retirement outputs
interface commit_unit_if #(
  parameter int AL_DEPTH = 64,
  parameter int FL_DEPTH = 64,
  parameter int PR_W     = 7,
  parameter int ADDR_W   = 32
);
  localparam int AL_W = $clog2(AL_DEPTH);
  localparam int FL_W = $clog2(FL_DEPTH);
  logic              flush;
  logic              al_head_valid;
  logic              al_head_ready;
  logic              al_head_is_load;
  logic              al_head_is_store;
  logic              al_head_is_branch;
  logic              al_head_uses_rw;
  logic [PR_W-1:0]   al_head_reclaim;
  logic [ADDR_W-1:0] sq_head_addr;
  logic [ADDR_W-1:0] sq_head_data;
  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [ADDR_W-1:0] dc_wr_data;
  logic              dc_wr_ack;
  logic [AL_W-1:0]   head_ptr;
  logic              head_color;
  logic              commit_valid;
  logic [AL_W-1:0]   commit_al_id;
  logic              load_done;
  logic              store_done;
  logic              branch_done;
  logic              free_wr_en;
  logic [PR_W-1:0]   free_wr_preg;
  logic [FL_W-1:0]   free_tail_ptr;
  logic [31:0]       retired_count;
  modport master (
    input  flush, al_head_valid, al_head_ready, al_head_is_load, al_head_is_store,
           al_head_is_branch, al_head_uses_rw, al_head_reclaim, sq_head_addr, sq_head_data,
           dc_wr_ack,
    output dc_wr_req, dc_wr_addr, dc_wr_data, head_ptr, head_color, commit_valid, commit_al_id,
           load_done, store_done, branch_done, free_wr_en, free_wr_preg, free_tail_ptr,
           retired_count
  );
  modport slave (
    output flush, al_head_valid, al_head_ready, al_head_is_load, al_head_is_store,
           al_head_is_branch, al_head_uses_rw, al_head_reclaim, sq_head_addr, sq_head_data,
           dc_wr_ack,
    input  dc_wr_req, dc_wr_addr, dc_wr_data, head_ptr, head_color, commit_valid, commit_al_id,
           load_done, store_done, branch_done, free_wr_en, free_wr_preg, free_tail_ptr,
           retired_count
  );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement of the active-list head, one per cycle; stores drain to D-cache first
module commit_unit #(
  parameter int AL_DEPTH = 64,
  parameter int FL_DEPTH = 64,
  parameter int PR_W     = 7,
  parameter int ADDR_W   = 32
) (
  input logic           clk,
  input logic           rst,
  commit_unit_if.master bus
);
  typedef enum logic {IDLE, ST_WAIT} state_t;
  state_t          state, state_d;
  logic            eligible, take_store, ack_fire, retire, retire_rw, st_rw;
  logic [PR_W-1:0] retire_preg, st_preg;
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  // the store's reclaim info is captured on entry so the ack-time retire does not depend on head inputs
  always_comb begin
    eligible    = state == IDLE && bus.al_head_valid && bus.al_head_ready && !bus.flush;
    take_store  = eligible && bus.al_head_is_store;
    ack_fire    = state == ST_WAIT && bus.dc_wr_req && bus.dc_wr_ack;
    retire      = (eligible && !bus.al_head_is_store) || ack_fire;
    retire_rw   = ack_fire ? st_rw : bus.al_head_uses_rw;
    retire_preg = ack_fire ? st_preg : bus.al_head_reclaim;
    state_d     = take_store ? ST_WAIT : ack_fire ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.head_ptr      <= '0;
      bus.head_color    <= 1'b0;
      bus.free_tail_ptr <= '0;
      bus.retired_count <= '0;
      bus.commit_valid  <= 1'b0;
      bus.commit_al_id  <= '0;
      bus.load_done     <= 1'b0;
      bus.store_done    <= 1'b0;
      bus.branch_done   <= 1'b0;
      bus.free_wr_en    <= 1'b0;
      bus.free_wr_preg  <= '0;
      bus.dc_wr_req     <= 1'b0;
      bus.dc_wr_addr    <= '0;
      bus.dc_wr_data    <= '0;
      st_rw             <= 1'b0;
      st_preg           <= '0;
    end else begin
      bus.commit_valid <= retire;
      bus.load_done    <= eligible && !bus.al_head_is_store && bus.al_head_is_load;
      bus.branch_done  <= eligible && !bus.al_head_is_store && bus.al_head_is_branch;
      bus.store_done   <= ack_fire;
      bus.free_wr_en   <= retire && retire_rw;
      if (retire) begin
        bus.commit_al_id  <= bus.head_ptr;
        bus.head_ptr      <= bus.head_ptr + 1'b1;
        bus.head_color    <= (&bus.head_ptr) ? ~bus.head_color : bus.head_color;
        bus.retired_count <= bus.retired_count + 32'd1;
      end
      if (retire && retire_rw) begin
        bus.free_wr_preg  <= retire_preg;
        bus.free_tail_ptr <= bus.free_tail_ptr + 1'b1;
      end
      if (take_store) begin
        bus.dc_wr_req  <= 1'b1;
        bus.dc_wr_addr <= bus.sq_head_addr;
        bus.dc_wr_data <= bus.sq_head_data;
        st_rw          <= bus.al_head_uses_rw;
        st_preg        <= bus.al_head_reclaim;
      end else if (ack_fire) begin
        bus.dc_wr_req <= 1'b0;
      end
    end
  end
endmodule
